instr_queue: RTL and testbench



---
 rtl/instr_queue_pkg.sv | 25 ++
 rtl/instr_queue.sv | 90 +++++++++
 tb/tb_instr_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// if_id_type is the fetch/decode pipeline register payload used across the core.
package instr_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic        instr_valid;
        logic        predict;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_type;

    typedef if_id_type [1:0] fetch_pair_t;

    // Number of entries carried by a legal slot-valid pattern; 2'b10 carries none.
    function automatic logic [1:0] slot_count(input logic [1:0] v);
        case (v)
            2'b11:   return 2'd2;
            2'b01:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_queue.sv
// In-order two-wide instruction queue between fetch and the dual decode slots.
// Fetch pushes up to a pair per cycle, decode pops 0/1/2 from the head, flush empties it.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic [1:0]       in_valid_i,
    input  fetch_pair_t      in_instr_i,
    output logic             in_ready_o,
    output logic [1:0]       out_valid_o,
    output fetch_pair_t      out_instr_o,
    input  logic [1:0]       out_accept_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    if_id_type        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_en;
    logic [1:0]       np;
    logic [1:0]       npop;

    // Ready only looks at the registered count so decode accept never feeds back to fetch.
    assign in_ready_o = (count <= CNT_W'(DEPTH - 2));
    assign count_o    = count;
    assign push_en    = in_ready_o && !flush_i;
    assign np         = push_en ? slot_count(in_valid_i) : 2'd0;

    always_comb begin
        out_valid_o[0] = (count >= CNT_W'(1)) && !flush_i;
        out_valid_o[1] = (count >= CNT_W'(2)) && !flush_i;
        out_instr_o    = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            if (out_valid_o[k]) begin
                out_instr_o[k]             = mem[rd_ptr + PTR_W'(k)];
                out_instr_o[k].instr_valid = 1'b1;
            end
        end
    end

    // Slot 1 is only consumed together with slot 0; a lone slot-1 accept pops nothing.
    assign npop = {1'b0, out_accept_i[0] & out_valid_o[0]}
                + {1'b0, out_accept_i[0] & out_accept_i[1] & out_valid_o[1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(npop);
            wr_ptr <= wr_ptr + PTR_W'(np);
            count  <= count + CNT_W'(np) - CNT_W'(npop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && in_valid_i[0]) begin
            mem[wr_ptr] <= in_instr_i[0];
        end
        if (push_en && (in_valid_i == 2'b11)) begin
            mem[wr_ptr + PTR_W'(1)] <= in_instr_i[1];
        end
    end

    a_in_valid_legal : assert property (@(posedge clk) disable iff (!reset_n)
        in_valid_i != 2'b10)
        else $warning("instr_queue: illegal in_valid_i encoding 2'b10 dropped");

    a_accept_legal : assert property (@(posedge clk) disable iff (!reset_n)
        out_accept_i != 2'b10)
        else $warning("instr_queue: illegal out_accept_i encoding 2'b10 ignored");

    a_count_bound : assert property (@(posedge clk) disable iff (!reset_n)
        count <= CNT_W'(DEPTH))
        else $error("instr_queue: occupancy exceeded DEPTH");

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH = 8).
module tb_instr_queue;
    import instr_queue_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        flush_i;
    logic [1:0]  in_valid_i;
    fetch_pair_t in_instr_i;
    logic        in_ready_o;
    logic [1:0]  out_valid_o;
    fetch_pair_t out_instr_o;
    logic [1:0]  out_accept_i;
    logic [3:0]  count_o;

    int compared;
    int mismatched;

    instr_queue #(.DEPTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_instr_i   (in_instr_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .out_instr_o  (out_instr_o),
        .out_accept_i (out_accept_i),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic if_id_type mk(input int id, input logic iv);
        if_id_type e;
        e.instr_valid = iv;
        e.predict     = id[0];
        e.pc          = 32'h0000_1000 + 32'(id * 4);
        e.instr       = 32'hC0DE_0000 ^ 32'(id);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input if_id_type e1, input if_id_type e0,
                         input logic [1:0] acc, input logic fl);
        in_valid_i      = v;
        in_instr_i[1]   = e1;
        in_instr_i[0]   = e0;
        out_accept_i    = acc;
        flush_i         = fl;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        #12;
        chk("rst_valid", 128'(out_valid_o), 128'(2'b00));
        chk("rst_count", 128'(count_o), 128'(0));
        chk("rst_ready", 128'(in_ready_o), 128'(1));
        chk("rst_instr", 128'(out_instr_o), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // A/B then C/D; A pushed with instr_valid clear to see it forced on output
        drive(2'b11, mk(2, 1'b1), mk(1, 1'b0), 2'b00, 1'b0);
        tick();
        chk("ab_count", 128'(count_o), 128'(2));
        drive(2'b11, mk(4, 1'b1), mk(3, 1'b1), 2'b00, 1'b0);
        tick();
        chk("cd_count", 128'(count_o), 128'(4));
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        #1;
        chk("ab_valid", 128'(out_valid_o), 128'(2'b11));
        chk("head0_A", 128'(out_instr_o[0]), 128'(mk(1, 1'b1)));
        chk("head1_B", 128'(out_instr_o[1]), 128'(mk(2, 1'b1)));

        drive(2'b11, mk(6, 1'b1), mk(5, 1'b1), 2'b00, 1'b0);
        tick();
        chk("c6_count", 128'(count_o), 128'(6));
        chk("c6_ready", 128'(in_ready_o), 128'(1));
        drive(2'b01, '0, mk(7, 1'b1), 2'b00, 1'b0);
        tick();
        chk("c7_count", 128'(count_o), 128'(7));
        chk("c7_ready", 128'(in_ready_o), 128'(0));
        drive(2'b11, mk(9, 1'b1), mk(8, 1'b1), 2'b00, 1'b0);
        tick();
        chk("c7_push_ignored", 128'(count_o), 128'(7));
        drive(2'b00, '0, '0, 2'b01, 1'b0);
        #1;
        chk("pop_A", 128'(out_instr_o[0]), 128'(mk(1, 1'b1)));
        tick();
        chk("pop1_count", 128'(count_o), 128'(6));
        chk("pop1_ready", 128'(in_ready_o), 128'(1));
        chk("head_B", 128'(out_instr_o[0]), 128'(mk(2, 1'b1)));

        // Flush at count 6 with push and accept in the same cycle
        drive(2'b11, mk(11, 1'b1), mk(10, 1'b1), 2'b11, 1'b1);
        #1;
        chk("flush_mask", 128'(out_valid_o), 128'(2'b00));
        chk("flush_instr", 128'(out_instr_o), 128'(0));
        tick();
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        #1;
        chk("flush_count", 128'(count_o), 128'(0));
        chk("flush_valid", 128'(out_valid_o), 128'(2'b00));
        drive(2'b11, mk(13, 1'b1), mk(12, 1'b1), 2'b00, 1'b0);
        tick();
        chk("xy_count", 128'(count_o), 128'(2));
        chk("xy_head0", 128'(out_instr_o[0]), 128'(mk(12, 1'b1)));
        chk("xy_head1", 128'(out_instr_o[1]), 128'(mk(13, 1'b1)));
        drive(2'b00, '0, '0, 2'b11, 1'b0);
        tick();
        chk("xy_drain", 128'(count_o), 128'(0));

        // Steady state push 11 / accept 11 across several pointer wraps
        drive(2'b11, mk(17, 1'b1), mk(16, 1'b1), 2'b00, 1'b0);
        tick();
        for (int j = 0; j < 20; j++) begin
            drive(2'b11, mk(19 + 2 * j, 1'b1), mk(18 + 2 * j, 1'b1), 2'b11, 1'b0);
            #1;
            chk("ss_head0", 128'(out_instr_o[0]), 128'(mk(16 + 2 * j, 1'b1)));
            chk("ss_head1", 128'(out_instr_o[1]), 128'(mk(17 + 2 * j, 1'b1)));
            tick();
            chk("ss_count", 128'(count_o), 128'(2));
        end
        drive(2'b00, '0, '0, 2'b11, 1'b0);
        #1;
        chk("ss_tail0", 128'(out_instr_o[0]), 128'(mk(56, 1'b1)));
        chk("ss_tail1", 128'(out_instr_o[1]), 128'(mk(57, 1'b1)));
        tick();
        chk("ss_empty", 128'(count_o), 128'(0));

        // count = 1 with accept 11 pops exactly one
        drive(2'b01, '0, mk(100, 1'b1), 2'b00, 1'b0);
        tick();
        drive(2'b00, '0, '0, 2'b11, 1'b0);
        #1;
        chk("one_valid", 128'(out_valid_o), 128'(2'b01));
        chk("one_head", 128'(out_instr_o[0]), 128'(mk(100, 1'b1)));
        chk("one_slot1", 128'(out_instr_o[1]), 128'(0));
        tick();
        chk("one_pop", 128'(count_o), 128'(0));

        // Illegal accept 10 and push 10 are no-ops
        drive(2'b01, '0, mk(101, 1'b1), 2'b00, 1'b0);
        tick();
        drive(2'b00, '0, '0, 2'b10, 1'b0);
        tick();
        chk("acc10_nopop", 128'(count_o), 128'(1));
        drive(2'b10, mk(102, 1'b1), '0, 2'b00, 1'b0);
        tick();
        chk("push10_drop", 128'(count_o), 128'(1));
        drive(2'b00, '0, '0, 2'b01, 1'b0);
        #1;
        chk("acc10_head", 128'(out_instr_o[0]), 128'(mk(101, 1'b1)));
        tick();
        chk("acc10_drain", 128'(count_o), 128'(0));

        // Asynchronous reset mid-fill at count 5
        drive(2'b11, mk(201, 1'b1), mk(200, 1'b1), 2'b00, 1'b0);
        tick();
        drive(2'b11, mk(203, 1'b1), mk(202, 1'b1), 2'b00, 1'b0);
        tick();
        drive(2'b01, '0, mk(204, 1'b1), 2'b00, 1'b0);
        tick();
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        #1;
        chk("fill5_count", 128'(count_o), 128'(5));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 128'(count_o), 128'(0));
        chk("arst_valid", 128'(out_valid_o), 128'(2'b00));
        chk("arst_ready", 128'(in_ready_o), 128'(1));
        chk("arst_instr", 128'(out_instr_o), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
